// File: rtl/rob_multi_commit.sv
`default_nettype none
// ============================================================================
// Module  : rob_multi_commit
// Brief   : Multi-lane reorder buffer with in-order retirement and precise
//           squash on mispredicted branches and exceptions.
// Revision: 1.0 - initial release
// ============================================================================
module rob_multi_commit #(
  parameter  int DEPTH          = 64,
  parameter  int DISPATCH_WIDTH = 2,
  parameter  int COMMIT_WIDTH   = 2,
  parameter  int WB_WIDTH       = 4,
  parameter  int ARCH_REGS      = 64,
  parameter  int PHYS_REGS      = 128,
  localparam int IDX_W          = $clog2(DEPTH),
  localparam int AW             = $clog2(ARCH_REGS),
  localparam int PW             = $clog2(PHYS_REGS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DISPATCH_WIDTH-1:0]    disp_valid_i,
  input  logic [DISPATCH_WIDTH-1:0]    disp_rd_wen_i,
  input  logic [DISPATCH_WIDTH*AW-1:0] disp_rd_arch_i,
  input  logic [DISPATCH_WIDTH*PW-1:0] disp_rd_new_prf_i,
  input  logic [DISPATCH_WIDTH*PW-1:0] disp_rd_old_prf_i,
  output logic [DISPATCH_WIDTH-1:0]    disp_ready_o,
  output logic [DISPATCH_WIDTH-1:0]    disp_alloc_o,
  output logic [DISPATCH_WIDTH*IDX_W-1:0] disp_rob_idx_o,
  input  logic [WB_WIDTH-1:0]          wb_valid_i,
  input  logic [WB_WIDTH*IDX_W-1:0]    wb_rob_idx_i,
  input  logic [WB_WIDTH-1:0]          wb_exception_i,
  input  logic [WB_WIDTH-1:0]          wb_mispred_i,
  output logic [COMMIT_WIDTH-1:0]      commit_valid_o,
  output logic [COMMIT_WIDTH-1:0]      commit_rd_wen_o,
  output logic [COMMIT_WIDTH*AW-1:0]   commit_rd_arch_o,
  output logic [COMMIT_WIDTH*PW-1:0]   commit_new_prf_o,
  output logic [COMMIT_WIDTH*PW-1:0]   commit_old_prf_o,
  output logic                         flush_o,
  output logic [IDX_W-1:0]             flush_rob_idx_o,
  output logic                         exception_o,
  output logic [IDX_W:0]               count_o,
  output logic                         empty_o
);

  localparam logic [IDX_W:0] c_depth = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0] c_one   = (IDX_W+1)'(1);

  logic [IDX_W:0]    r_head, r_tail;
  logic [DEPTH-1:0]  r_valid, r_done, r_exc, r_mispred, r_rd_wen;
  logic [AW-1:0]     r_rd_arch [DEPTH];
  logic [PW-1:0]     r_new_prf [DEPTH];
  logic [PW-1:0]     r_old_prf [DEPTH];

  logic [IDX_W:0]    w_count, w_free, w_nalloc, w_ncommit;
  logic [DISPATCH_WIDTH-1:0] w_ready, w_alloc;
  logic              w_blocked, w_stop;
  logic [IDX_W-1:0]  w_disp_idx [DISPATCH_WIDTH];
  logic [IDX_W-1:0]  w_head_idx [COMMIT_WIDTH];
  logic [COMMIT_WIDTH-1:0] w_commit;
  logic              w_flush, w_exc_flush;
  logic [IDX_W-1:0]  w_flush_idx;
  logic [DEPTH-1:0]  w_wb_hit, w_wb_exc, w_wb_mis, w_set, w_clr;

  // Retire window: stop at the first not-ready entry, an exception, or after a mispredict.
  always_comb begin
    w_commit    = '0;
    w_ncommit   = '0;
    w_flush     = 1'b0;
    w_exc_flush = 1'b0;
    w_flush_idx = '0;
    w_stop      = 1'b0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      w_head_idx[k] = r_head[IDX_W-1:0] + IDX_W'(k);
      if (!w_stop) begin
        if (r_valid[w_head_idx[k]] && r_done[w_head_idx[k]]) begin
          if (r_exc[w_head_idx[k]]) begin
            w_flush     = 1'b1;
            w_exc_flush = 1'b1;
            w_flush_idx = w_head_idx[k];
            w_stop      = 1'b1;
          end else begin
            w_commit[k] = 1'b1;
            w_ncommit   = w_ncommit + c_one;
            if (r_mispred[w_head_idx[k]]) begin
              w_flush     = 1'b1;
              w_flush_idx = w_head_idx[k];
              w_stop      = 1'b1;
            end
          end
        end else begin
          w_stop = 1'b1;
        end
      end
    end
  end

  // Allocation is an in-order prefix of the requesting lanes.
  always_comb begin
    w_count   = r_tail - r_head;
    w_free    = c_depth - w_count;
    w_nalloc  = '0;
    w_blocked = 1'b0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      w_ready[i]    = (w_free > (IDX_W+1)'(i)) && !w_flush;
      w_alloc[i]    = reset && disp_valid_i[i] && w_ready[i] && !w_blocked;
      w_blocked     = w_blocked | (disp_valid_i[i] & ~w_alloc[i]);
      w_disp_idx[i] = r_tail[IDX_W-1:0] + w_nalloc[IDX_W-1:0];
      if (w_alloc[i]) w_nalloc = w_nalloc + c_one;
    end
  end

  always_comb begin
    w_wb_hit = '0;
    w_wb_exc = '0;
    w_wb_mis = '0;
    w_set    = '0;
    w_clr    = '0;
    for (int l = 0; l < WB_WIDTH; l++) begin
      if (wb_valid_i[l]) begin
        w_wb_hit[wb_rob_idx_i[l*IDX_W +: IDX_W]] = 1'b1;
        w_wb_exc[wb_rob_idx_i[l*IDX_W +: IDX_W]] =
          w_wb_exc[wb_rob_idx_i[l*IDX_W +: IDX_W]] | wb_exception_i[l];
        w_wb_mis[wb_rob_idx_i[l*IDX_W +: IDX_W]] =
          w_wb_mis[wb_rob_idx_i[l*IDX_W +: IDX_W]] | wb_mispred_i[l];
      end
    end
    for (int i = 0; i < DISPATCH_WIDTH; i++)
      if (w_alloc[i]) w_set[w_disp_idx[i]] = 1'b1;
    for (int k = 0; k < COMMIT_WIDTH; k++)
      if (w_commit[k]) w_clr[w_head_idx[k]] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_valid   <= '0;
      r_done    <= '0;
      r_exc     <= '0;
      r_mispred <= '0;
    end else if (w_flush) begin
      // Mispredict: head moves past the branch; exception: head stays on the faulting entry.
      r_head    <= r_head + w_ncommit;
      r_tail    <= r_head + w_ncommit;
      r_valid   <= '0;
      r_done    <= '0;
      r_exc     <= '0;
      r_mispred <= '0;
    end else begin
      r_head <= r_head + w_ncommit;
      r_tail <= r_tail + w_nalloc;
      for (int e = 0; e < DEPTH; e++) begin
        if (w_set[e]) begin
          r_valid[e]   <= 1'b1;
          r_done[e]    <= 1'b0;
          r_exc[e]     <= 1'b0;
          r_mispred[e] <= 1'b0;
        end else begin
          if (w_clr[e]) r_valid[e] <= 1'b0;
          if (w_wb_hit[e] && r_valid[e]) begin
            r_done[e]    <= 1'b1;
            r_exc[e]     <= r_exc[e] | w_wb_exc[e];
            r_mispred[e] <= r_mispred[e] | w_wb_mis[e];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      if (w_alloc[i]) begin
        r_rd_wen[w_disp_idx[i]]  <= disp_rd_wen_i[i];
        r_rd_arch[w_disp_idx[i]] <= disp_rd_arch_i[i*AW +: AW];
        r_new_prf[w_disp_idx[i]] <= disp_rd_new_prf_i[i*PW +: PW];
        r_old_prf[w_disp_idx[i]] <= disp_rd_old_prf_i[i*PW +: PW];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DISPATCH_WIDTH; i++)
      disp_rob_idx_o[i*IDX_W +: IDX_W] = w_disp_idx[i];
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      commit_rd_wen_o[k]             = r_rd_wen[w_head_idx[k]];
      commit_rd_arch_o[k*AW +: AW]   = r_rd_arch[w_head_idx[k]];
      commit_new_prf_o[k*PW +: PW]   = r_new_prf[w_head_idx[k]];
      commit_old_prf_o[k*PW +: PW]   = r_old_prf[w_head_idx[k]];
    end
  end

  assign disp_ready_o    = w_ready;
  assign disp_alloc_o    = w_alloc;
  assign commit_valid_o  = w_commit;
  assign flush_o         = w_flush;
  assign exception_o     = w_exc_flush;
  assign flush_rob_idx_o = w_flush_idx;
  assign count_o         = w_count;
  assign empty_o         = (w_count == '0);

endmodule
`default_nettype wire

// File: tb/tb_rob_multi_commit.sv
`default_nettype none
// ============================================================================
// Module  : tb_rob_multi_commit
// Brief   : Directed scoreboard bench for rob_multi_commit (DEPTH = 8 build).
// Revision: 1.0 - initial release
// ============================================================================
module tb_rob_multi_commit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  disp_valid_i, disp_rd_wen_i, disp_ready_o, disp_alloc_o;
  logic [11:0] disp_rd_arch_i;
  logic [13:0] disp_rd_new_prf_i, disp_rd_old_prf_i;
  logic [5:0]  disp_rob_idx_o;
  logic [3:0]  wb_valid_i, wb_exception_i, wb_mispred_i;
  logic [11:0] wb_rob_idx_i;
  logic [1:0]  commit_valid_o, commit_rd_wen_o;
  logic [11:0] commit_rd_arch_o;
  logic [13:0] commit_new_prf_o, commit_old_prf_o;
  logic        flush_o, exception_o, empty_o;
  logic [2:0]  flush_rob_idx_o;
  logic [3:0]  count_o;

  int total = 0;
  int bad   = 0;
  logic [20:0] exp_q[$];
  logic [3:0]  flush_q[$];

  rob_multi_commit #(.DEPTH(8)) dut (
    .clk(clk), .reset(reset),
    .disp_valid_i(disp_valid_i), .disp_rd_wen_i(disp_rd_wen_i),
    .disp_rd_arch_i(disp_rd_arch_i), .disp_rd_new_prf_i(disp_rd_new_prf_i),
    .disp_rd_old_prf_i(disp_rd_old_prf_i), .disp_ready_o(disp_ready_o),
    .disp_alloc_o(disp_alloc_o), .disp_rob_idx_o(disp_rob_idx_o),
    .wb_valid_i(wb_valid_i), .wb_rob_idx_i(wb_rob_idx_i),
    .wb_exception_i(wb_exception_i), .wb_mispred_i(wb_mispred_i),
    .commit_valid_o(commit_valid_o), .commit_rd_wen_o(commit_rd_wen_o),
    .commit_rd_arch_o(commit_rd_arch_o), .commit_new_prf_o(commit_new_prf_o),
    .commit_old_prf_o(commit_old_prf_o), .flush_o(flush_o),
    .flush_rob_idx_o(flush_rob_idx_o), .exception_o(exception_o),
    .count_o(count_o), .empty_o(empty_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    disp_valid_i = '0; disp_rd_wen_i = '0; disp_rd_arch_i = '0;
    disp_rd_new_prf_i = '0; disp_rd_old_prf_i = '0;
    wb_valid_i = '0; wb_rob_idx_i = '0; wb_exception_i = '0; wb_mispred_i = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic set_disp(input logic [1:0] v, input int a0, input int n0, input int o0,
                          input int a1, input int n1, input int o1);
    disp_valid_i      = v;
    disp_rd_wen_i     = v;
    disp_rd_arch_i    = {6'(a1), 6'(a0)};
    disp_rd_new_prf_i = {7'(n1), 7'(n0)};
    disp_rd_old_prf_i = {7'(o1), 7'(o0)};
  endtask

  task automatic set_wb(input int lane, input int idx, input logic exc, input logic mis);
    wb_valid_i[lane]         = 1'b1;
    wb_rob_idx_i[lane*3 +: 3] = 3'(idx);
    wb_exception_i[lane]     = exc;
    wb_mispred_i[lane]       = mis;
  endtask

  task automatic push(input int a, input int n, input int o);
    exp_q.push_back({1'b1, 6'(a), 7'(n), 7'(o)});
  endtask

  // Monitor: retire lanes and flush pulses are matched against the queues in order.
  initial begin
    logic [20:0] e;
    logic [3:0]  f;
    forever begin
      @(negedge clk);
      if (reset) begin
        for (int k = 0; k < 2; k++) begin
          if (commit_valid_o[k]) begin
            if (exp_q.size() == 0) begin
              total++; bad++;
              $display("FAIL commit_unexpected: lane %0d arch %0d", k, commit_rd_arch_o[k*6 +: 6]);
            end else begin
              e = exp_q.pop_front();
              chk("commit_payload", 32'({commit_rd_wen_o[k], commit_rd_arch_o[k*6 +: 6],
                  commit_new_prf_o[k*7 +: 7], commit_old_prf_o[k*7 +: 7]}), 32'(e));
            end
          end
        end
        if (flush_o) begin
          if (flush_q.size() == 0) begin
            total++; bad++;
            $display("FAIL flush_unexpected: idx %0d exc %0d", flush_rob_idx_o, exception_o);
          end else begin
            f = flush_q.pop_front();
            chk("flush_info", 32'({exception_o, flush_rob_idx_o}), 32'(f));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    disp_valid_i = 2'b11;
    #12;
    chk("rst_alloc", 32'(disp_alloc_o), 32'd0);
    chk("rst_ready", 32'(disp_ready_o), 32'd3);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_commit", 32'({commit_valid_o, flush_o, exception_o}), 32'd0);
    clear_inputs();
    step();
    reset = 1'b1;
    step();

    // Single dispatch, writeback, retire.
    set_disp(2'b01, 1, 10, 2, 0, 0, 0);
    #1;
    chk("t1_idx", 32'(disp_rob_idx_o[2:0]), 32'd0);
    chk("t1_alloc", 32'(disp_alloc_o), 32'd1);
    push(1, 10, 2);
    step();
    chk("t1_count", 32'(count_o), 32'd1);
    set_wb(0, 0, 1'b0, 1'b0);
    step();
    chk("t1_commit", 32'(commit_valid_o), 32'd1);
    step();
    chk("t1_empty", 32'(empty_o), 32'd1);

    // Out-of-order completion, dual retire.
    set_disp(2'b11, 3, 11, 4, 5, 12, 6);
    #1;
    chk("t2_idx", 32'(disp_rob_idx_o), 32'({3'd2, 3'd1}));
    push(3, 11, 4); push(5, 12, 6);
    step();
    set_wb(0, 2, 1'b0, 1'b0);
    step();
    chk("t2_wait0", 32'(commit_valid_o), 32'd0);
    step();
    chk("t2_wait1", 32'(commit_valid_o), 32'd0);
    step();
    chk("t2_wait2", 32'(commit_valid_o), 32'd0);
    set_wb(1, 1, 1'b0, 1'b0);
    step();
    chk("t2_commit", 32'(commit_valid_o), 32'd3);
    step();
    chk("t2_empty", 32'(empty_o), 32'd1);

    // Mispredicted branch at idx 3 squashes 4 and 5.
    set_disp(2'b11, 7, 13, 8, 9, 14, 10);
    #1;
    chk("t3_idx", 32'(disp_rob_idx_o), 32'({3'd4, 3'd3}));
    push(7, 13, 8);
    step();
    set_disp(2'b01, 11, 15, 12, 0, 0, 0);
    #1;
    chk("t3_idx5", 32'(disp_rob_idx_o[2:0]), 32'd5);
    step();
    set_wb(0, 3, 1'b0, 1'b1); set_wb(1, 4, 1'b0, 1'b0); set_wb(2, 5, 1'b0, 1'b0);
    flush_q.push_back({1'b0, 3'd3});
    step();
    chk("t3_commit", 32'(commit_valid_o), 32'd1);
    chk("t3_flush", 32'({flush_o, exception_o, flush_rob_idx_o}), 32'({1'b1, 1'b0, 3'd3}));
    step();
    chk("t3_count", 32'(count_o), 32'd0);

    // Exception at idx 5 after idx 4 retires.
    set_disp(2'b11, 13, 16, 14, 15, 17, 16);
    #1;
    chk("t4_idx", 32'(disp_rob_idx_o), 32'({3'd5, 3'd4}));
    push(13, 16, 14);
    step();
    set_wb(0, 4, 1'b0, 1'b0); set_wb(1, 5, 1'b1, 1'b0);
    flush_q.push_back({1'b1, 3'd5});
    step();
    chk("t4_commit", 32'(commit_valid_o), 32'd1);
    chk("t4_flush", 32'({flush_o, exception_o, flush_rob_idx_o}), 32'({1'b1, 1'b1, 3'd5}));
    step();
    chk("t4_count", 32'(count_o), 32'd0);

    // Lane 0 idle, lane 1 takes the tail index.
    set_disp(2'b10, 0, 0, 0, 20, 20, 21);
    #1;
    chk("t6_alloc", 32'(disp_alloc_o), 32'd2);
    chk("t6_idx", 32'(disp_rob_idx_o[5:3]), 32'd5);
    push(20, 20, 21);
    step();
    set_wb(3, 5, 1'b0, 1'b0);
    step();
    chk("t6_commit", 32'(commit_valid_o), 32'd1);
    step();

    // Exception and mispredict on one entry: exception wins.
    set_disp(2'b01, 22, 22, 23, 0, 0, 0);
    #1;
    chk("t7_idx", 32'(disp_rob_idx_o[2:0]), 32'd6);
    step();
    set_wb(0, 6, 1'b1, 1'b1);
    flush_q.push_back({1'b1, 3'd6});
    step();
    chk("t7_flush", 32'({commit_valid_o, flush_o, exception_o, flush_rob_idx_o}),
        32'({2'b00, 1'b1, 1'b1, 3'd6}));
    step();

    // Reset mid-operation clears state immediately.
    set_disp(2'b01, 24, 24, 25, 0, 0, 0);
    step();
    chk("t8_count_pre", 32'(count_o), 32'd1);
    reset = 1'b0;
    #1;
    chk("t8_count_rst", 32'(count_o), 32'd0);
    chk("t8_flush_rst", 32'(flush_o), 32'd0);
    step();
    reset = 1'b1;
    step();

    // Fill, reverse completion, dual retire, wrap.
    for (int c = 0; c < 4; c++) begin
      set_disp(2'b11, 32 + 2*c, 64 + 2*c, 96 + 2*c, 33 + 2*c, 65 + 2*c, 97 + 2*c);
      #1;
      chk("t5_ready", 32'(disp_ready_o), 32'd3);
      chk("t5_idx", 32'(disp_rob_idx_o), 32'({3'(2*c + 1), 3'(2*c)}));
      push(32 + 2*c, 64 + 2*c, 96 + 2*c); push(33 + 2*c, 65 + 2*c, 97 + 2*c);
      step();
    end
    chk("t5_full_count", 32'(count_o), 32'd8);
    set_disp(2'b11, 50, 50, 50, 51, 51, 51);
    #1;
    chk("t5_full_ready", 32'(disp_ready_o), 32'd0);
    chk("t5_full_alloc", 32'(disp_alloc_o), 32'd0);
    clear_inputs();
    for (int c = 3; c >= 0; c--) begin
      set_wb(0, 2*c + 1, 1'b0, 1'b0); set_wb(1, 2*c, 1'b0, 1'b0);
      step();
      if (c != 0) chk("t5_nocommit", 32'(commit_valid_o), 32'd0);
    end
    for (int c = 0; c < 4; c++) begin
      chk("t5_dual", 32'(commit_valid_o), 32'd3);
      if (c == 0) begin
        set_disp(2'b11, 50, 50, 50, 51, 51, 51);
        #1;
        chk("t5_full_commit_alloc", 32'(disp_alloc_o), 32'd0);
      end
      step();
    end
    chk("t5_empty", 32'(empty_o), 32'd1);
    set_disp(2'b01, 40, 41, 42, 0, 0, 0);
    #1;
    chk("t5_wrap_idx", 32'(disp_rob_idx_o[2:0]), 32'd0);
    push(40, 41, 42);
    step();
    set_wb(0, 0, 1'b0, 1'b0);
    step();
    chk("t5_wrap_commit", 32'(commit_valid_o), 32'd1);
    step();
    step();
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("flush_q_empty", 32'(flush_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rob_multi_commit.md
Name: rob_multi_commit

Overview:
- Parameterised reorder buffer for the R10K-style out-of-order core. Sits between rename/dispatch, the writeback buses and the retirement/freelist logic.
- Allocates up to DISPATCH_WIDTH entries per cycle and accepts WB_WIDTH completions per cycle.
- Retires up to COMMIT_WIDTH entries in order.
- Adds precise recovery over the previous ROB: a mispredicted branch retires and squashes all younger entries; an excepting instruction squashes itself and everything younger.

Parameters:
- DEPTH, 64, number of entries; power of 2, at least 4.
- DISPATCH_WIDTH, 2, allocation lanes.
- COMMIT_WIDTH, 2, retire lanes.
- WB_WIDTH, 4, writeback lanes.
- ARCH_REGS, 64, architectural register count.
- PHYS_REGS, 128, physical register count.
- Derived: IDX_W = $clog2(DEPTH), AW = $clog2(ARCH_REGS), PW = $clog2(PHYS_REGS).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low.
- disp_valid_i  in  DISPATCH_WIDTH  lane i requests allocation.
- disp_rd_wen_i  in  DISPATCH_WIDTH  instruction writes rd.
- disp_rd_arch_i  in  DISPATCH_WIDTH x AW  architectural rd.
- disp_rd_new_prf_i  in  DISPATCH_WIDTH x PW  new physical rd.
- disp_rd_old_prf_i  in  DISPATCH_WIDTH x PW  previous mapping of rd.
- disp_ready_o  out  DISPATCH_WIDTH  lane i may allocate this cycle.
- disp_alloc_o  out  DISPATCH_WIDTH  lane i allocated at the next edge.
- disp_rob_idx_o  out  DISPATCH_WIDTH x IDX_W  index given to lane i.
- wb_valid_i  in  WB_WIDTH  completion valid.
- wb_rob_idx_i  in  WB_WIDTH x IDX_W  completing entry.
- wb_exception_i  in  WB_WIDTH  completion raised an exception.
- wb_mispred_i  in  WB_WIDTH  completion was a mispredicted branch.
- commit_valid_o  out  COMMIT_WIDTH  retire lane valid.
- commit_rd_wen_o  out  COMMIT_WIDTH  retiring entry writes rd.
- commit_rd_arch_o  out  COMMIT_WIDTH x AW  retiring entry's architectural rd.
- commit_new_prf_o  out  COMMIT_WIDTH x PW  retiring entry's new physical rd.
- commit_old_prf_o  out  COMMIT_WIDTH x PW  retiring entry's old mapping, to be freed.
- flush_o  out  1  squash pulse.
- flush_rob_idx_o  out  IDX_W  index of the entry causing the flush.
- exception_o  out  1  the flush is due to an exception.
- count_o  out  IDX_W+1  occupied entries.
- empty_o  out  1  count_o == 0.

Behaviour:
- Storage and pointers:
  - Circular buffer with head and tail pointers of IDX_W+1 bits (wrap bit) and a per-entry valid/done/exc/mispred state.
  - count = tail - head; full when count == DEPTH.
- Reset (reset low, asynchronous): head = tail = 0; all valid/done/exc/mispred bits cleared.
  - Outputs: commit_valid_o, flush_o, exception_o, disp_alloc_o are 0; count_o is 0; empty_o is 1.
  - disp_ready_o is all-ones; payload outputs are don't-care.
- Dispatch:
  - disp_ready_o[i] = (DEPTH - count > i) && !flush_o. This uses the registered count; slots freed by this cycle's commits are not counted.
  - Allocation is an in-order prefix: lane i allocates iff disp_valid_i[i], disp_ready_o[i], and every lane j<i with disp_valid_i[j] also allocates.
  - Allocated lanes take consecutive indices starting at tail[IDX_W-1:0]. An invalid lane takes no index.
  - disp_rob_idx_o is combinational. Tail advances by the allocation count.
  - The new entry is written with done = 0.
- Writeback:
  - At the edge, for each lane with wb_valid_i set and the target entry valid: set done, and OR in exc and mispred.
  - A writeback to an invalid entry is ignored.
  - Duplicate indices on two lanes in the same cycle are legal; flags are OR-merged.
  - Writeback to an entry allocated in the same cycle is not possible, because its index is not yet visible.
- Commit (combinational from registered state):
  - Lane k is valid iff entry head+k is valid and done, all lanes below k are valid, and no lane below k is a mispredict or exception.
  - An exc entry never asserts commit_valid_o.
  - A mispred entry commits and is the last lane of its group.
  - Head advances by the number of commits.
- Flush:
  - Triggers in the same cycle:
    - Mispredict: a committing lane is mispred. flush_o = 1, exception_o = 0, flush_rob_idx_o = that index.
    - Exception: the first non-committed done entry in the window is exc, and all lanes before it commit. flush_o = 1, exception_o = 1, flush_rob_idx_o = that index.
  - At the edge:
    - All entries are invalidated and tail = head_next.
    - Mispredict: head_next is the index after the branch.
    - Exception: head_next is the excepting index, so it is not retired.
  - Dispatch and writeback in the flush cycle are discarded. count_o is 0 on the next cycle.
  - If exception and mispred are both set on one entry, exception wins.
- Wrap-around: indices are taken mod DEPTH; all pointer arithmetic wraps on IDX_W+1 bits.
- Simultaneous events:
  - Full ROB plus commit in the same cycle: no dispatch that cycle; it is accepted next cycle.
  - Reset asserted mid-operation: state clears immediately; no flush pulse is generated.

Test Plan:
- Reset, then dispatch one lane (arch 1, new 10, old 2), then WB idx 0 -> disp_rob_idx_o[0] = 0; commit_valid_o = 01 the cycle after WB with arch 1, new 10, old 2; empty_o returns to 1.
- Dual dispatch to idx 1 and 2; WB idx 2, then idx 1 three cycles later -> no commit until idx 1 is done; then commit_valid_o = 11 in a single cycle, in order idx 1 then idx 2.
- Dispatch idx 3, 4, 5; WB all, with idx 3 mispred -> commit_valid_o = 01 (idx 3 only); flush_o = 1, flush_rob_idx_o = 3, exception_o = 0; count_o = 0 next cycle; the next dispatch gets idx 4.
- Dispatch idx 4 and 5; WB idx 4 normal, idx 5 exception -> idx 4 commits; flush_o = 1, exception_o = 1, flush_rob_idx_o = 5; idx 5 is never committed; the next dispatch gets idx 5.
- DEPTH = 8 build:
  - Dispatch 2 per cycle until full -> disp_ready_o = 00 at count 8.
  - WB in reverse order (7/6 ... 1/0) -> no commits until idx 0 and 1 are done, then 2 commits per cycle for 4 cycles.
  - Pointers wrap, and the next allocation gets idx 0.
- Dispatch with valid = 10 (lane 0 idle) -> lane 1 allocates at tail; disp_alloc_o = 10.
